// File: rtl/arb_pkg.sv
// Shared definitions for the 4-source round-robin arbiter.
package arb_pkg;
  localparam int NUM_SRC = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [1:0] sel_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);

  sel_t cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 sources with hold-until-done and a hold-time limit.
// Grant appears 1 cycle after a request is seen in IDLE; one dead cycle separates grants.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               done,
  output logic [NUM_SRC-1:0] grant,
  output logic [1:0]         select,
  output logic               valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  sel_t               select_q, select_d;
  logic               valid_q, valid_d;
  sel_t               ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic found;
  sel_t pick_idx;
  logic release_now;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  // Any release cause gives the same single transition back to IDLE.
  assign release_now = done | ~req[select_q] | (hold_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = BUSY;
          grant_d  = 4'(1) << pick_idx;
          select_d = pick_idx;
          valid_d  = 1'b1;
          hold_d   = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d  = IDLE;
          grant_d  = '0;
          select_d = 2'd0;
          valid_d  = 1'b0;
          ptr_d    = select_q + 2'd1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= 2'd0;
      valid_q  <= 1'b0;
      ptr_q    <= 2'd0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, the maximum consecutive cycles one grant is held; legal range 1..255.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port req  input  4  per-source request, bit i = source i.
REQ-005 Port done  input  1  the current grant holder signals end of transfer.
REQ-006 Port grant  output  4  one-hot grant, or all-zero when idle.
REQ-007 Port select  output  2  binary index of the granted source; drives the select input of the downstream 4-way mux.
REQ-008 Port valid  output  1  high exactly when grant is non-zero.

Function
REQ-009 The FSM SHALL have two states: IDLE and BUSY.
REQ-010 In IDLE with req != 0 at a rising edge, the block SHALL grant the first requesting source at or after index ptr, searching upward modulo 4, and enter BUSY; grant becomes visible after that edge, so latency is 1 cycle.
REQ-011 In IDLE with req == 0, grant SHALL stay 0 and the state SHALL stay IDLE.
REQ-012 In BUSY, grant and select SHALL stay constant until release.
REQ-013 Release SHALL occur at the edge where any of these holds: done=1; req[select]=0; or the hold counter equals MAX_HOLD-1.
REQ-014 On release, the block SHALL set ptr to (select+1) mod 4, clear grant, and return to IDLE; this gives exactly one dead cycle between grants.
REQ-015 The hold counter SHALL clear on entry to BUSY and increment once per BUSY cycle without release.
REQ-016 The hold counter width SHALL be $clog2(MAX_HOLD+1) bits, and the counter SHALL never wrap.
REQ-017 ptr SHALL wrap from 3 to 0.
REQ-018 Requests from other sources during BUSY SHALL not change grant; they are only evaluated in IDLE.
REQ-019 When several release conditions coincide, a single release SHALL occur, with the same next state and ptr update as for any one condition.
REQ-020 select SHALL be 0 whenever valid=0.
REQ-021 All outputs SHALL be registered; none may depend combinationally on req or done.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force: state=IDLE, grant=4'b0000, select=2'b00, valid=0, ptr=0, hold counter=0.
REQ-023 Reset asserted during BUSY SHALL drop the grant asynchronously, without waiting for a clock edge.
REQ-024 After reset deassertion, the first grant SHALL follow REQ-010 with ptr=0.

Structure
REQ-025 A shared package arb_pkg SHALL hold NUM_SRC=4, the state enum type (IDLE, BUSY), and the select index typedef logic [1:0].
REQ-026 Priority search SHALL be a combinational sub-module rr_pick4, with inputs req[3:0] and ptr[1:0], and outputs found and idx[1:0].
REQ-027 rr_arbiter4 SHALL contain the FSM, ptr, the hold counter, and the output registers.

Verification
REQ-028 Reset, then req=4'b1010 held, done pulsed after each grant -> grants in order 1, 3, 1, 3, with valid low for one cycle between grants.
REQ-029 req=4'b1111, done=0, MAX_HOLD=8 -> each grant lasts exactly 8 cycles, and select cycles through 0, 1, 2, 3, 0.
REQ-030 Grant to source 2 active, req[2] dropped mid-transfer -> release at the next edge, ptr=3, and source 3 is granted next if it is requesting.
REQ-031 rst_n pulsed low mid-BUSY between clock edges -> grant=0, valid=0, select=0 immediately, and after release the first grant goes to the lowest-index requester.
REQ-032 done=1 and hold limit reached on the same edge with req=4'b0001 -> exactly one release, one idle cycle, then source 0 is re-granted.
REQ-033 Throughout every scenario, the bench SHALL assert that grant is one-hot or zero, that valid equals (grant != 0), and that select equals the index of the grant bit.
